// File: rtl/ascii_parser.sv
// ASCII decimal string (LSD-first char layout, MSD consumed first) to 32-bit binary.
// Optional feature: define NEG_EN to accept a leading '-' sign and return two's complement.
module ascii_parser #(
  parameter int MAX_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MAX_LEN*8-1:0] str,
  input  logic [7:0]           length,
  output logic [31:0]          value,
  output logic                 ready,
  output logic                 error
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [1:0]               state_q, state_d;
  logic [MAX_LEN-1:0][7:0]  str_q, str_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [31:0]              acc_q, acc_d;
  logic [31:0]              value_q, value_d;
  logic                     ready_q, ready_d;
  logic                     error_q, error_d;
`ifdef NEG_EN
  logic [7:0]               len_q, len_d;
  logic                     neg_q, neg_d;
`endif

  logic [7:0]  c;
  logic        is_digit;
  logic        is_sign;
  logic [31:0] acc_nx;

  assign c        = str_q[idx_q];
  assign is_digit = (c >= 8'h30) && (c <= 8'h39);
  // acc*10 as shift-add; 8 digits cannot overflow 32 bits
  assign acc_nx   = (acc_q << 3) + (acc_q << 1) + {28'd0, c[3:0]};

`ifdef NEG_EN
  // sign only legal as the first (most significant) char and never as the whole string
  assign is_sign = (c == 8'h2D) && (8'(idx_q) == len_q - 8'd1) && (idx_q != '0);
`else
  assign is_sign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    str_d   = str_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    value_d = value_q;
    ready_d = ready_q;
    error_d = error_q;
`ifdef NEG_EN
    len_d   = len_q;
    neg_d   = neg_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          str_d   = str;
          acc_d   = '0;
          value_d = '0;
          ready_d = 1'b0;
          error_d = 1'b0;
`ifdef NEG_EN
          len_d   = length;
          neg_d   = 1'b0;
`endif
          if (length == 8'd0 || length > 8'(MAX_LEN)) begin
            state_d = S_DONE;
            error_d = 1'b1;
            ready_d = 1'b1;
          end else begin
            idx_d   = IW'(length - 8'd1);
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (is_sign) begin
`ifdef NEG_EN
          neg_d = 1'b1;
`endif
          idx_d = idx_q - 1'b1;
        end else if (!is_digit) begin
          state_d = S_DONE;
          error_d = 1'b1;
          ready_d = 1'b1;
          value_d = '0;
        end else begin
          acc_d = acc_nx;
          if (idx_q == '0) begin
`ifdef NEG_EN
            value_d = neg_q ? (~acc_nx + 32'd1) : acc_nx;
`else
            value_d = acc_nx;
`endif
            ready_d = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      str_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      value_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
`ifdef NEG_EN
      len_q   <= '0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      str_q   <= str_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      value_q <= value_d;
      ready_q <= ready_d;
      error_q <= error_d;
`ifdef NEG_EN
      len_q   <= len_d;
      neg_q   <= neg_d;
`endif
    end
  end

  assign value = value_q;
  assign ready = ready_q;
  assign error = error_q;
endmodule

// File: tb/tb_ascii_parser.sv
// Scoreboard bench for ascii_parser: expected results queued at start, checked at ready.
module tb_ascii_parser;
  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] str;
  logic [7:0]  length;
  logic [31:0] value;
  logic        ready;
  logic        error;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] v;
    logic        e;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sb[$];

  ascii_parser #(.MAX_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .str(str), .length(length),
    .value(value), .ready(ready), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pack(input string s);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < s.len() && k < 8; k++) r[8*k +: 8] = s[s.len()-1-k];
    return r;
  endfunction

  // Drive one start edge, queue the expectation, then scramble inputs to prove latching.
  task automatic launch(input string name, input string s, input int len,
                        input logic [31:0] ev, input logic ee, input int elat);
    exp_t x;
    str = pack(s); length = len[7:0]; start = 1'b1;
    @(posedge clk); #1;
    x.name = name; x.v = ev; x.e = ee; x.lat = elat; x.t0 = cyc;
    sb.push_back(x);
    start = 1'b0; str = {$urandom, $urandom}; length = 8'($urandom);
  endtask

  task automatic collect();
    exp_t x;
    int guard = 0;
    while (!ready && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    x = sb.pop_front();
    vectors++;
    if (!ready) begin
      miscompares++;
      $display("FAIL %s timeout: ready=%b required 1", x.name, ready);
      return;
    end
    vectors++;
    if (value !== x.v) begin
      miscompares++;
      $display("FAIL %s value: got %h required %h", x.name, value, x.v);
    end
    vectors++;
    if (error !== x.e) begin
      miscompares++;
      $display("FAIL %s error: got %b required %b", x.name, error, x.e);
    end
    vectors++;
    if (cyc - x.t0 != x.lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d required %0d", x.name, cyc - x.t0, x.lat);
    end
  endtask

  task automatic conv(input string name, input string s, input int len,
                      input logic [31:0] ev, input logic ee, input int elat);
    launch(name, s, len, ev, ee, elat);
    collect();
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (value !== 32'd0 || ready !== 1'b0 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: value=%h ready=%b error=%b required 0/0/0", name, value, ready, error);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; str = '0; length = '0;
    repeat (2) @(posedge clk);
    #1 check_idle("reset");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_idle("idle_no_start");
  endtask

  task automatic test_basic();
    conv("42", "42", 2, 32'd42, 1'b0, 2);
    conv("max8", "99999999", 8, 32'h05F5E0FF, 1'b0, 8);
    conv("zeros", "007", 3, 32'd7, 1'b0, 3);
    conv("single0", "0", 1, 32'd0, 1'b0, 1);
    conv("12345678", "12345678", 8, 32'd12345678, 1'b0, 8);
  endtask

  task automatic test_invalid();
    conv("4a", "4a", 2, 32'd0, 1'b1, 2);
    conv("x_first", "x12", 3, 32'd0, 1'b1, 1);
    conv("colon", "1:", 2, 32'd0, 1'b1, 2);
    conv("slash", "/", 1, 32'd0, 1'b1, 1);
  endtask

  task automatic test_bad_length();
    conv("len0", "5", 0, 32'd0, 1'b1, 0);
    conv("len9", "12345678", 9, 32'd0, 1'b1, 0);
    conv("len255", "1", 255, 32'd0, 1'b1, 0);
  endtask

  task automatic test_done_hold();
    conv("hold_src", "314", 3, 32'd314, 1'b0, 3);
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (value !== 32'd314 || ready !== 1'b1 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL done_hold: value=%h ready=%b error=%b required 13a/1/0", value, ready, error);
    end
  endtask

  task automatic test_start_ignored();
    launch("ign_scan", "12345", 5, 32'd12345, 1'b0, 5);
    @(posedge clk); #1;
    str = pack("9"); length = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    collect();
  endtask

  task automatic test_reset_mid();
    launch("rst_mid_unused", "12345", 5, 32'd0, 1'b0, 0);
    void'(sb.pop_front());
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check_idle("reset_mid");
    repeat (6) @(posedge clk);
    #1 check_idle("after_reset_mid");
    conv("restart7", "7", 1, 32'd7, 1'b0, 1);
  endtask

  task automatic test_sign();
`ifdef NEG_EN
    conv("neg17", "-17", 3, 32'hFFFFFFEF, 1'b0, 3);
    conv("neg_max", "-9999999", 8, 32'hFF676981, 1'b0, 8);
    conv("mid_minus", "1-2", 3, 32'd0, 1'b1, 2);
`else
    conv("neg17", "-17", 3, 32'd0, 1'b1, 1);
    conv("mid_minus", "1-2", 3, 32'd0, 1'b1, 2);
`endif
    conv("only_minus", "-", 1, 32'd0, 1'b1, 1);
  endtask

  task automatic test_back_to_back();
    conv("b2b_a", "65535", 5, 32'd65535, 1'b0, 5);
    conv("b2b_len_err", "1", 0, 32'd0, 1'b1, 0);
    conv("b2b_b", "1000000", 7, 32'd1000000, 1'b0, 7);
    conv("b2b_c", "8", 1, 32'd8, 1'b0, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_bad_length();
    test_done_hold();
    test_start_ignored();
    test_reset_mid();
    test_sign();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
